multi_edge_detector: RTL and testbench

- Parametrised, multi-channel successor to the single-bit edge detector.
- Each channel synchronises an asynchronous input (switch, button), debounces it, and emits a registered debounced level plus one-cycle rising/falling pulses, with a per-channel edge mask and an aggregate any-edge pulse.
- Sits between board I/O pins and the reaction-timer control FSM.

---
 rtl/edge_pkg.sv | 20 ++
 rtl/debounce_channel.sv | 64 ++++++
 rtl/multi_edge_detector.sv | 96 +++++++++
 tb/tb_multi_edge_detector.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_pkg.sv
// Shared constants, edge event type and counter sizing for multi_edge_detector.
package edge_pkg;

  localparam int unsigned SYNC_STAGES_MIN = 2;
  localparam int unsigned SYNC_STAGES_MAX = 4;
  localparam int unsigned DEBOUNCE_MAX    = 65535;

  // Outcome of one channel's debounce decision in a given cycle.
  typedef enum logic [1:0] {
    EDGE_NONE,
    EDGE_RISE,
    EDGE_FALL
  } edge_t;

  // Counter must hold values 0..cycles-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One channel: synchroniser chain, stability counter and debounced level register.
// edge_o reports, combinationally, the flip accepted at the coming clock edge.
module debounce_channel
  import edge_pkg::*;
#(
  parameter int unsigned SyncStages     = 2,
  parameter int unsigned DebounceCycles = 16,
  parameter bit          InitLevel      = 1'b0
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  sig_i,
  output logic  level_o,
  output edge_t edge_o
);

  localparam int unsigned     CntW   = cnt_width(DebounceCycles);
  localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles - 1);

  logic [SyncStages-1:0] sync_q;
  logic                  syncd;
  logic [CntW-1:0]       cnt_d, cnt_q;
  logic                  level_d, level_q;

  assign syncd = sync_q[SyncStages-1];

  // Plain flop chain, no logic between stages.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {SyncStages{InitLevel}};
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], sig_i};
    end
  end

  // Count consecutive cycles that disagree with the level; flip on the last one.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    edge_o  = EDGE_NONE;
    if (syncd != level_q) begin
      if (cnt_q == CntMax) begin
        level_d = syncd;
        edge_o  = syncd ? EDGE_RISE : EDGE_FALL;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  // Counter and accepted level state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      level_q <= InitLevel;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/multi_edge_detector.sv
// Multi-channel synchronise/debounce/edge-detect block with per-channel edge mask
// and an aggregate any-edge pulse. Optional sticky event flags under
// MULTI_EDGE_STICKY_EN.
module multi_edge_detector
  import edge_pkg::*;
#(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter bit          INIT_LEVEL      = 1'b0
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic [WIDTH-1:0] signalIn,
  input  logic [WIDTH-1:0] edgeMask,
`ifdef MULTI_EDGE_STICKY_EN
  input  logic [WIDTH-1:0] eventClear,
  output logic [WIDTH-1:0] eventFlags,
`endif
  output logic [WIDTH-1:0] signalOut,
  output logic [WIDTH-1:0] risingEdge,
  output logic [WIDTH-1:0] fallingEdge,
  output logic             anyEdge
);

  // Out-of-range parameters are pulled back into the supported range.
  localparam int unsigned SyncStagesEff =
      (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN :
      (SYNC_STAGES > SYNC_STAGES_MAX) ? SYNC_STAGES_MAX : SYNC_STAGES;
  localparam int unsigned DebounceEff =
      (DEBOUNCE_CYCLES < 1) ? 1 :
      (DEBOUNCE_CYCLES > DEBOUNCE_MAX) ? DEBOUNCE_MAX : DEBOUNCE_CYCLES;

  edge_t            flip [WIDTH];
  logic [WIDTH-1:0] rise_d, rise_q;
  logic [WIDTH-1:0] fall_d, fall_q;
  logic             any_d, any_q;

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    debounce_channel #(
      .SyncStages    (SyncStagesEff),
      .DebounceCycles(DebounceEff),
      .InitLevel     (INIT_LEVEL)
    ) u_ch (
      .clk_i  (clk),
      .rst_ni (resetN),
      .sig_i  (signalIn[g]),
      .level_o(signalOut[g]),
      .edge_o (flip[g])
    );
  end

  // Mask is applied to the flip decision so pulses line up with the new level.
  always_comb begin
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      rise_d[i] = (flip[i] == EDGE_RISE) && !edgeMask[i];
      fall_d[i] = (flip[i] == EDGE_FALL) && !edgeMask[i];
    end
    any_d = |(rise_d | fall_d);
  end

  // Registered edge pulses and their OR.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      rise_q <= '0;
      fall_q <= '0;
      any_q  <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
      any_q  <= any_d;
    end
  end

  assign risingEdge  = rise_q;
  assign fallingEdge = fall_q;
  assign anyEdge     = any_q;

`ifdef MULTI_EDGE_STICKY_EN
  logic [WIDTH-1:0] flags_q;

  // Flags latch visible edge pulses; a coincident clear loses to the set.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      flags_q <= '0;
    end else begin
      flags_q <= (flags_q & ~eventClear) | rise_q | fall_q;
    end
  end

  assign eventFlags = flags_q;
`endif

endmodule

// File: tb/tb_multi_edge_detector.sv
// Self-checking bench for multi_edge_detector: table-driven directed vectors,
// hand-written multi-cycle sequences and randomized stimulus against a
// sliding-window reference model.
module tb_multi_edge_detector;

  localparam int SYNC = 2;
  localparam int DEB  = 16;
  localparam int HIST = SYNC + DEB;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic [3:0] sig_in = '0;
  logic [3:0] mask = '0;
  logic [3:0] ev_clr = '0;
  logic [3:0] out0, rise0, fall0;
  logic       any0;
  logic [3:0] flags0;
  logic [3:0] sig1 = 4'hF;
  logic [3:0] mask1 = '0;
  logic [3:0] clr1 = '0;
  logic [3:0] out1, rise1, fall1;
  logic       any1;
  logic [3:0] flags1;

  always #5 clk = ~clk;

  multi_edge_detector #(
    .WIDTH(4), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .INIT_LEVEL(1'b0)
  ) dut (
    .clk        (clk),
    .resetN     (resetN),
    .signalIn   (sig_in),
    .edgeMask   (mask),
`ifdef MULTI_EDGE_STICKY_EN
    .eventClear (ev_clr),
    .eventFlags (flags0),
`endif
    .signalOut  (out0),
    .risingEdge (rise0),
    .fallingEdge(fall0),
    .anyEdge    (any0)
  );

  multi_edge_detector #(
    .WIDTH(4), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .INIT_LEVEL(1'b1)
  ) dut_init1 (
    .clk        (clk),
    .resetN     (resetN),
    .signalIn   (sig1),
    .edgeMask   (mask1),
`ifdef MULTI_EDGE_STICKY_EN
    .eventClear (clr1),
    .eventFlags (flags1),
`endif
    .signalOut  (out1),
    .risingEdge (rise1),
    .fallingEdge(fall1),
    .anyEdge    (any1)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: raw input history, newest at index 0. A level flips when
  // every synchronised sample in the last DEB cycles disagrees with it.
  logic [3:0] hist [HIST];
  logic [3:0] m_level, m_rise, m_fall, m_flags;
  logic       m_any;
  logic [3:0] r_seen, f_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < HIST; i++) hist[i] = 4'h0;
    m_level = 4'h0;
    m_rise  = 4'h0;
    m_fall  = 4'h0;
    m_any   = 1'b0;
    m_flags = 4'h0;
  endtask

  task automatic model_step();
    bit differ;
    m_flags = (m_flags & ~ev_clr) | m_rise | m_fall;
    for (int i = HIST - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = sig_in;
    for (int ch = 0; ch < 4; ch++) begin
      differ = 1'b1;
      for (int j = SYNC; j < HIST; j++) if (hist[j][ch] == m_level[ch]) differ = 1'b0;
      m_rise[ch] = differ && !m_level[ch] && !mask[ch];
      m_fall[ch] = differ &&  m_level[ch] && !mask[ch];
      if (differ) m_level[ch] = ~m_level[ch];
    end
    m_any = |(m_rise | m_fall);
  endtask

  // One clock: advance the model, then compare every output away from the edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("signalOut", 32'(out0), 32'(m_level));
    chk("risingEdge", 32'(rise0), 32'(m_rise));
    chk("fallingEdge", 32'(fall0), 32'(m_fall));
    chk("anyEdge", 32'(any0), 32'(m_any));
`ifdef MULTI_EDGE_STICKY_EN
    chk("eventFlags", 32'(flags0), 32'(m_flags));
`endif
    chk("init1_signalOut", 32'(out1), 32'hF);
    chk("init1_edges", 32'(rise1 | fall1 | {3'b0, any1}), 32'h0);
    r_seen |= rise0;
    f_seen |= fall0;
  endtask

  task automatic assert_rst();
    resetN = 1'b0;
    #1;
    model_reset();
    chk("reset_signalOut", 32'(out0), 32'h0);
    chk("reset_edges", 32'(rise0 | fall0 | {3'b0, any0}), 32'h0);
  endtask

  task automatic release_rst();
    repeat (2) @(posedge clk);
    #1;
    resetN = 1'b1;
  endtask

  typedef struct {
    bit         rst;
    int         hold;
    logic [3:0] sig;
    logic [3:0] msk;
    logic [3:0] exp_out;
    logic [3:0] exp_rise;
    logic [3:0] exp_fall;
  } vec_t;

  vec_t tbl[$];
  int   n;

  initial begin
    // rst, hold, signalIn, edgeMask, signalOut after, rises seen, falls seen
    tbl.push_back('{1'b1, 20, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000});
    tbl.push_back('{1'b0, 17, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000});
    tbl.push_back('{1'b0,  1, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0000});
    tbl.push_back('{1'b0, 15, 4'b0011, 4'b0000, 4'b0001, 4'b0000, 4'b0000});
    tbl.push_back('{1'b0, 20, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000});
    tbl.push_back('{1'b0, 16, 4'b0011, 4'b0000, 4'b0001, 4'b0000, 4'b0000});
    tbl.push_back('{1'b0,  2, 4'b0001, 4'b0000, 4'b0011, 4'b0010, 4'b0000});
    tbl.push_back('{1'b0, 20, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0010});
    tbl.push_back('{1'b1, 18, 4'b1111, 4'b0100, 4'b1111, 4'b1011, 4'b0000});
    tbl.push_back('{1'b0, 18, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1111});

    model_reset();
    assert_rst();
    release_rst();

    foreach (tbl[k]) begin
      if (tbl[k].rst) begin
        sig_in = 4'h0;
        assert_rst();
        release_rst();
      end
      sig_in = tbl[k].sig;
      mask   = tbl[k].msk;
      r_seen = '0;
      f_seen = '0;
      repeat (tbl[k].hold) tick();
      chk($sformatf("vec%0d_signalOut", k), 32'(out0), 32'(tbl[k].exp_out));
      chk($sformatf("vec%0d_rises", k), 32'(r_seen), 32'(tbl[k].exp_rise));
      chk($sformatf("vec%0d_falls", k), 32'(f_seen), 32'(tbl[k].exp_fall));
    end

    // Reset at count 10 of a ch2 rise; the rise must then requalify in full.
    sig_in = 4'h0;
    mask   = 4'h0;
    assert_rst();
    release_rst();
    sig_in = 4'b0100;
    repeat (12) tick();
    chk("midrst_before", 32'(out0), 32'h0);
    assert_rst();
    release_rst();
    r_seen = '0;
    f_seen = '0;
    n = 0;
    while (!out0[2] && n < 40) begin
      tick();
      n++;
    end
    chk("midrst_latency", 32'(n), 32'd18);
    chk("midrst_no_fall", 32'(f_seen), 32'h0);
    chk("midrst_rise", 32'(r_seen), 32'b0100);

    // Asynchronous reset drops an accepted high level without a clock edge.
    resetN = 1'b0;
    #1;
    model_reset();
    chk("async_rst_level", 32'(out0), 32'h0);
    sig_in = 4'h0;
    release_rst();

`ifdef MULTI_EDGE_STICKY_EN
    sig_in = 4'b1000;
    repeat (18) tick();
    sig_in = 4'b0000;
    repeat (20) tick();
    chk("sticky_hold", 32'(flags0[3]), 32'd1);
    ev_clr = 4'b1000;
    tick();
    ev_clr = 4'b0000;
    chk("sticky_lone_clear", 32'(flags0[3]), 32'd0);
    sig_in = 4'b1000;
    n = 0;
    while (!rise0[3] && n < 40) begin
      tick();
      n++;
    end
    chk("sticky_rise_seen", 32'(rise0[3]), 32'd1);
    ev_clr = 4'b1000;
    tick();
    ev_clr = 4'b0000;
    chk("sticky_set_wins", 32'(flags0[3]), 32'd1);
`endif

    // Randomized phase: slow random toggles mix accepted edges with glitches.
    sig_in = 4'h0;
    mask   = 4'h0;
    assert_rst();
    release_rst();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        assert_rst();
        release_rst();
      end
      if ($urandom_range(11) == 0) sig_in[$urandom_range(3)] = ~sig_in[$urandom_range(3)];
      if ($urandom_range(11) == 0) sig_in = 4'($urandom);
      if ($urandom_range(49) == 0) mask = 4'($urandom);
      ev_clr = ($urandom_range(3) == 0) ? 4'($urandom) : 4'h0;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
